instruction_aligner: RTL and testbench

// - Sits between the fetch stage (aligned 32-bit I-memory words) and rvc_expander.
// - Splits each word into halfword-aligned instructions: 16-bit RVC or 32-bit, including 32-bit ones straddling two words.
// - Emits one instruction per cycle with its PC and a compressed flag, through a registered valid/ready output.
// - Handles redirects (flush) to any halfword-aligned PC.

---
 rtl/instruction_aligner_pkg.sv | 22 ++
 rtl/instruction_aligner_split.sv | 87 ++++++++
 rtl/instruction_aligner.sv | 99 +++++++++
 tb/tb_instruction_aligner.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_aligner_pkg.sv
// Shared types for the instruction aligner: alignment states, issue record and length test.
package instruction_aligner_pkg;

    typedef enum logic [1:0] {
        S_ALIGNED = 2'd0,
        S_SKIP    = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    localparam logic [1:0] INSTR_LEN32 = 2'b11;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } issue_t;

    // Only 16- and 32-bit encodings exist here; longer formats are not recognised.
    function automatic logic is_len32(input logic [15:0] half);
        return half[1:0] == INSTR_LEN32;
    endfunction

endpackage

// File: rtl/instruction_aligner_split.sv
// Combinational issue-select: picks the next instruction from hold/word and the next alignment state.
// Zero latency; issues or consumes only when the caller's load is high.
module instruction_aligner_split
    import instruction_aligner_pkg::*;
(
    input  state_e      state,
    input  logic [15:0] hold,
    input  logic [31:0] hold_pc,
    input  logic        word_ok,
    input  logic [31:0] word,
    input  logic [31:0] word_pc,
    input  logic        load,
    output logic        issue_vld,
    output issue_t      issue_dat,
    output logic        use_word,
    output logic [15:0] hold_nxt,
    output logic [31:0] hold_pc_nxt,
    output state_e      state_nxt
);

    always_comb begin
        issue_vld   = 1'b0;
        issue_dat   = '0;
        use_word    = 1'b0;
        hold_nxt    = hold;
        hold_pc_nxt = hold_pc;
        state_nxt   = state;

        case (state)
            S_ALIGNED: begin
                if (word_ok && load) begin
                    use_word  = 1'b1;
                    issue_vld = 1'b1;
                    issue_dat.pc = word_pc;
                    if (is_len32(word[15:0])) begin
                        issue_dat.instr = word;
                    end else begin
                        issue_dat.instr = {16'h0000, word[15:0]};
                        hold_nxt        = word[31:16];
                        hold_pc_nxt     = word_pc + 32'd2;
                        state_nxt       = S_HOLD;
                    end
                end
            end

            S_SKIP: begin
                // Entered on a redirect to pc[1]=1: the low half belongs to the old path.
                if (word_ok && load) begin
                    use_word = 1'b1;
                    if (is_len32(word[31:16])) begin
                        hold_nxt    = word[31:16];
                        hold_pc_nxt = word_pc + 32'd2;
                        state_nxt   = S_HOLD;
                    end else begin
                        issue_vld       = 1'b1;
                        issue_dat.instr = {16'h0000, word[31:16]};
                        issue_dat.pc    = word_pc + 32'd2;
                        state_nxt       = S_ALIGNED;
                    end
                end
            end

            S_HOLD: begin
                if (!is_len32(hold)) begin
                    if (load) begin
                        issue_vld       = 1'b1;
                        issue_dat.instr = {16'h0000, hold};
                        issue_dat.pc    = hold_pc;
                        state_nxt       = S_ALIGNED;
                    end
                end else if (word_ok && load) begin
                    use_word        = 1'b1;
                    issue_vld       = 1'b1;
                    issue_dat.instr = {word[15:0], hold};
                    issue_dat.pc    = hold_pc;
                    hold_nxt        = word[31:16];
                    hold_pc_nxt     = word_pc + 32'd2;
                end
            end

            default: begin
                state_nxt = S_ALIGNED;
            end
        endcase
    end

endmodule

// File: rtl/instruction_aligner.sv
// Splits aligned 32-bit fetch words into 16/32-bit instructions with PC, one per cycle.
// Latency 1 cycle word->valid_o; a stalled output (valid_o & !ready_i) stops consumption of words.
module instruction_aligner
    import instruction_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_word_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_ready_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        is_compressed_o,
    output logic        valid_o,
    input  logic        ready_i
);

    localparam state_e RESET_STATE = RESET_PC[1] ? S_SKIP : S_ALIGNED;

    state_e      state_r;
    logic [15:0] hold_r;
    logic [31:0] hold_pc_r;
    logic [31:0] next_fetch_pc_r;

    logic        load;
    logic        pc_match;
    logic        word_ok;
    logic        word_drop;
    logic        issue_vld;
    issue_t      issue_dat;
    logic        use_word;
    logic [15:0] hold_nxt;
    logic [31:0] hold_pc_nxt;
    state_e      state_nxt;

    assign load      = !valid_o || ready_i;
    assign pc_match  = fetch_pc_i == next_fetch_pc_r;
    assign word_ok   = fetch_valid_i && pc_match;
    // Words still in flight from before a redirect carry the wrong address and are thrown away.
    assign word_drop = fetch_valid_i && !pc_match;

    assign fetch_ready_o = rst_i && !flush_i && (use_word || word_drop);

    instruction_aligner_split u_split (
        .state       (state_r),
        .hold        (hold_r),
        .hold_pc     (hold_pc_r),
        .word_ok     (word_ok),
        .word        (fetch_word_i),
        .word_pc     (fetch_pc_i),
        .load        (load),
        .issue_vld   (issue_vld),
        .issue_dat   (issue_dat),
        .use_word    (use_word),
        .hold_nxt    (hold_nxt),
        .hold_pc_nxt (hold_pc_nxt),
        .state_nxt   (state_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r         <= RESET_STATE;
            hold_r          <= 16'h0000;
            hold_pc_r       <= 32'h0000_0000;
            next_fetch_pc_r <= {RESET_PC[31:2], 2'b00};
            valid_o         <= 1'b0;
            instruction_o   <= 32'h0000_0000;
            pc_o            <= 32'h0000_0000;
            is_compressed_o <= 1'b0;
        end else if (flush_i) begin
            state_r         <= flush_pc_i[1] ? S_SKIP : S_ALIGNED;
            hold_r          <= 16'h0000;
            hold_pc_r       <= 32'h0000_0000;
            next_fetch_pc_r <= {flush_pc_i[31:2], 2'b00};
            valid_o         <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            hold_r    <= hold_nxt;
            hold_pc_r <= hold_pc_nxt;
            if (use_word) begin
                next_fetch_pc_r <= next_fetch_pc_r + 32'd4;
            end
            if (load) begin
                valid_o <= issue_vld;
                if (issue_vld) begin
                    instruction_o   <= issue_dat.instr;
                    pc_o            <= issue_dat.pc;
                    is_compressed_o <= !is_len32(issue_dat.instr[15:0]);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_aligner.sv
// Bench for instruction_aligner: halfword-stream reference model plus directed scenarios.
module tb_instruction_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic [31:0] fetch_word_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_ready_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        is_compressed_o;
    logic        valid_o;
    logic        ready_i;

    always #5 clk_i = ~clk_i;

    instruction_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_word_i    (fetch_word_i),
        .fetch_pc_i      (fetch_pc_i),
        .fetch_ready_o   (fetch_ready_o),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .instruction_o   (instruction_o),
        .pc_o            (pc_o),
        .is_compressed_o (is_compressed_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] fetch_addr;
    logic [31:0] fetch_limit;
    logic        fetch_on;
    logic [31:0] addr_q [$];
    logic        consumed = 1'b0;

    logic [31:0] mpc;
    logic [15:0] m_h;
    logic [31:0] m_exp;
    logic [31:0] m_len;
    logic [31:0] log_i [$];
    logic [31:0] log_pc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0001_0001;
    endfunction

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_rd({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: program memory read as a halfword stream from the current model PC.
    always @(negedge clk_i) begin
        consumed = fetch_valid_i && fetch_ready_o;
        if (rst_i && !flush_i && valid_o && ready_i) begin
            m_h = half_at(mpc);
            if (m_h[1:0] == 2'b11) begin
                m_exp = {half_at(mpc + 32'd2), m_h};
                m_len = 32'd4;
            end else begin
                m_exp = {16'h0000, m_h};
                m_len = 32'd2;
            end
            chk("stream_instr", instruction_o, m_exp);
            chk("stream_pc", pc_o, mpc);
            chk("stream_compressed", {31'b0, is_compressed_o}, {31'b0, m_h[1:0] != 2'b11});
            log_i.push_back(instruction_o);
            log_pc.push_back(pc_o);
            mpc = mpc + m_len;
        end
    end

    task automatic present();
        fetch_pc_i    = fetch_addr;
        fetch_word_i  = mem_rd(fetch_addr);
        fetch_valid_i = fetch_on && (fetch_addr != fetch_limit);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        if (consumed) begin
            if (addr_q.size() > 0) fetch_addr = addr_q.pop_front();
            else fetch_addr = fetch_addr + 32'd4;
        end
        present();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic begin_reset();
        rst_i    = 1'b0;
        flush_i  = 1'b0;
        fetch_on = 1'b0;
        present();
        run(2);
        mem.delete();
        addr_q.delete();
        log_i.delete();
        log_pc.delete();
        mpc        = 32'h0;
        fetch_addr = 32'h0;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] ei, input logic [31:0] ep);
        if (idx < log_i.size()) begin
            chk({name, "_instr"}, log_i[idx], ei);
            chk({name, "_pc"}, log_pc[idx], ep);
        end else begin
            chk({name, "_present"}, 32'(log_i.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        rst_i         = 1'b0;
        flush_i       = 1'b0;
        flush_pc_i    = 32'h0;
        ready_i       = 1'b1;
        fetch_valid_i = 1'b0;
        fetch_word_i  = 32'h0;
        fetch_pc_i    = 32'h0;
        mpc           = 32'h0;

        // Reset values, with a valid word offered during reset
        mem[32'h0]  = 32'h00B5_0533;
        mem[32'h4]  = 32'h0001_4501;
        fetch_addr  = 32'h0;
        fetch_limit = 32'h8;
        fetch_on    = 1'b1;
        present();
        run(2);
        @(negedge clk_i);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_instr", instruction_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_compressed", {31'b0, is_compressed_o}, 32'h0);
        chk("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        step();
        rst_i = 1'b1;
        run(10);
        chk("a_count", 32'(log_i.size()), 32'd3);
        chk_log("a0", 0, 32'h00B5_0533, 32'h0);
        chk_log("a1", 1, 32'h0000_4501, 32'h4);
        chk_log("a2", 2, 32'h0000_0001, 32'h6);

        // Straddling 32-bit instruction; trailing 32-bit half waits for a word
        begin_reset();
        mem[32'h0]  = 32'h0093_4501;
        mem[32'h4]  = 32'hABCF_0000;
        fetch_limit = 32'h8;
        fetch_on    = 1'b1;
        present();
        rst_i = 1'b1;
        run(10);
        chk("b_count", 32'(log_i.size()), 32'd2);
        chk_log("b0", 0, 32'h0000_4501, 32'h0);
        chk_log("b1", 1, 32'h0000_0093, 32'h2);
        chk("b_idle_valid", {31'b0, valid_o}, 32'h0);

        // Redirect to an odd halfword
        log_i.delete();
        log_pc.delete();
        mem[32'h100] = 32'h4505_0000;
        flush_pc_i   = 32'h102;
        flush_i      = 1'b1;
        mpc          = 32'h102;
        fetch_addr   = 32'h100;
        fetch_limit  = 32'h104;
        present();
        step();
        flush_i = 1'b0;
        run(8);
        chk("c_count", 32'(log_i.size()), 32'd1);
        chk_log("c0", 0, 32'h0000_4505, 32'h102);

        // Backpressure then a ragged ready pattern
        begin_reset();
        mem[32'h0]  = 32'h0001_4501;
        mem[32'h4]  = 32'h00B5_0533;
        mem[32'h8]  = 32'h4501_4505;
        fetch_limit = 32'h10;
        ready_i     = 1'b0;
        fetch_on    = 1'b1;
        present();
        rst_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (valid_o) break;
        end
        chk("d_valid_up", {31'b0, valid_o}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk_i);
            chk("d_stall_valid", {31'b0, valid_o}, 32'h1);
            chk("d_stall_instr", instruction_o, 32'h0000_4501);
            chk("d_stall_pc", pc_o, 32'h0);
            chk("d_stall_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            ready_i = (i % 3) != 2;
        end
        ready_i = 1'b1;
        run(5);
        chk("d_count", 32'(log_i.size()), 32'd7);
        chk_log("d3", 3, 32'h0000_4505, 32'h8);
        chk_log("d6", 6, 32'h0000_0001, 32'hE);

        // Flush while holding, with stale in-flight words
        begin_reset();
        mem[32'h0]  = 32'h0093_4501;
        mem[32'h8]  = 32'h1111_1111;
        mem[32'hC]  = 32'h2222_2222;
        mem[32'h40] = 32'h00B5_0533;
        fetch_limit = 32'h4;
        fetch_on    = 1'b1;
        present();
        rst_i = 1'b1;
        run(6);
        chk("e_pre_count", 32'(log_i.size()), 32'd1);
        log_i.delete();
        log_pc.delete();
        flush_pc_i  = 32'h40;
        flush_i     = 1'b1;
        mpc         = 32'h40;
        fetch_addr  = 32'h8;
        addr_q.push_back(32'hC);
        addr_q.push_back(32'h40);
        fetch_limit = 32'h44;
        present();
        @(negedge clk_i);
        chk("e_flush_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        chk("e_stale_drop_ready", {31'b0, fetch_ready_o}, 32'h1);
        run(10);
        chk("e_count", 32'(log_i.size()), 32'd1);
        chk_log("e0", 0, 32'h00B5_0533, 32'h40);

        // Async reset mid-straddle
        begin_reset();
        mem[32'h0]  = 32'h0093_4501;
        mem[32'h4]  = 32'h1237_0000;
        fetch_limit = 32'h4;
        ready_i     = 1'b0;
        fetch_on    = 1'b1;
        present();
        rst_i = 1'b1;
        run(4);
        chk("f_valid_before", {31'b0, valid_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("f_arst_valid", {31'b0, valid_o}, 32'h0);
        chk("f_arst_fetch_ready", {31'b0, fetch_ready_o}, 32'h0);
        log_i.delete();
        log_pc.delete();
        mpc         = 32'h0;
        fetch_addr  = 32'h0;
        fetch_limit = 32'h8;
        ready_i     = 1'b1;
        present();
        step();
        rst_i = 1'b1;
        run(10);
        chk("f_count", 32'(log_i.size()), 32'd2);
        chk_log("f0", 0, 32'h0000_4501, 32'h0);
        chk_log("f1", 1, 32'h0000_0093, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
